// File: rtl/reg_file_ctrl_pkg.sv
// Shared types and helpers for the register-file access controller.
// The CE helper works on a wide address so any ADDR_W up to MAX_ADDR_W can use it.
package reg_file_ctrl_pkg;

    localparam int DEF_ADDR_W = 2;
    localparam int DEF_DATA_W = 8;
    localparam int MAX_ADDR_W = 8;
    localparam int MAX_CE_W   = 2**MAX_ADDR_W;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        CAPTURE,
        RESP
    } state_t;

    // Callers cast the result down to their own 2**ADDR_W width.
    function automatic logic [MAX_CE_W-1:0] onehot_ce(input logic [MAX_ADDR_W-1:0] addr);
        logic [MAX_CE_W-1:0] ce;
        ce       = '0;
        ce[addr] = 1'b1;
        return ce;
    endfunction

endpackage

// File: rtl/reg_file_ctrl_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester at or after
// last_grant+1 (mod NREQ). The pointer register is owned by the caller.
module rr_arbiter
    import reg_file_ctrl_pkg::*;
#(
    parameter int NREQ  = 2,
    parameter int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] last_grant,
    input  logic             en,
    output logic [NREQ-1:0]  grant,
    output logic [IDX_W-1:0] grant_idx
);

    logic found;

    // Outer loop walks priority order, so the first hit is the round-robin winner.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (en && !found && req[i] && (i == ((int'(last_grant) + k) % NREQ))) begin
                    found     = 1'b1;
                    grant[i]  = 1'b1;
                    grant_idx = IDX_W'(i);
                end
            end
        end
    end

endmodule

// File: rtl/reg_file_ctrl.sv
// Shares a small register file between NREQ requesters, one transaction at a
// time, and sequences the file's registered one-cycle read latency.
module reg_file_ctrl
    import reg_file_ctrl_pkg::*;
#(
    parameter int NREQ   = 2,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic                   CLK,
    input  logic                   RSTN,
    input  logic [NREQ-1:0]        REQ_VALID,
    output logic [NREQ-1:0]        REQ_READY,
    input  logic [NREQ-1:0]        REQ_WE,
    input  logic [NREQ*ADDR_W-1:0] REQ_ADDR,
    input  logic [NREQ*DATA_W-1:0] REQ_WDATA,
    output logic [NREQ-1:0]        RSP_VALID,
    input  logic [NREQ-1:0]        RSP_READY,
    output logic [DATA_W-1:0]      RSP_RDATA,
    output logic [ADDR_W-1:0]      RF_ADDR,
    output logic [2**ADDR_W-1:0]   RF_CE,
    output logic [DATA_W-1:0]      RF_DATA_IN,
    input  logic [DATA_W-1:0]      RF_DATA_OUT,
    output logic                   BUSY
);

    localparam int NREG  = 2**ADDR_W;
    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    state_t            state;
    logic [IDX_W-1:0]  last_grant;
    logic [IDX_W-1:0]  grant_idx;
    logic [IDX_W-1:0]  req_id;
    logic [NREQ-1:0]   grant;
    logic              we_q;
    logic              arb_en;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic [ADDR_W-1:0] addr_a  [NREQ];
    logic [DATA_W-1:0] wdata_a [NREQ];

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            addr_a[i]  = REQ_ADDR[i*ADDR_W +: ADDR_W];
            wdata_a[i] = REQ_WDATA[i*DATA_W +: DATA_W];
        end
    end

    assign arb_en    = (state == IDLE);
    assign REQ_READY = grant;
    assign sel_we    = REQ_WE[grant_idx];
    assign sel_addr  = addr_a[grant_idx];
    assign sel_wdata = wdata_a[grant_idx];

    rr_arbiter #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_arb (
        .req        (REQ_VALID),
        .last_grant (last_grant),
        .en         (arb_en),
        .grant      (grant),
        .grant_idx  (grant_idx)
    );

    // RF_ADDR/RF_DATA_IN are loaded at accept and held until the next accept,
    // which keeps the file's DATA_OUT stable through CAPTURE. A write response
    // echoes the held RF_DATA_IN.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state      <= IDLE;
            last_grant <= IDX_W'(NREQ - 1);
            req_id     <= '0;
            we_q       <= 1'b0;
            RSP_VALID  <= '0;
            RSP_RDATA  <= '0;
            RF_ADDR    <= '0;
            RF_CE      <= '0;
            RF_DATA_IN <= '0;
            BUSY       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    RF_CE <= '0;
                    if (|grant) begin
                        req_id     <= grant_idx;
                        we_q       <= sel_we;
                        last_grant <= grant_idx;
                        RF_ADDR    <= sel_addr;
                        RF_DATA_IN <= sel_wdata;
                        RF_CE      <= sel_we ? NREG'(onehot_ce(MAX_ADDR_W'(sel_addr))) : '0;
                        BUSY       <= 1'b1;
                        state      <= ACCESS;
                    end
                end
                ACCESS: begin
                    RF_CE <= '0;
                    if (we_q) begin
                        RSP_RDATA <= RF_DATA_IN;
                        RSP_VALID <= NREQ'(1) << req_id;
                        state     <= RESP;
                    end else begin
                        state <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    RF_CE     <= '0;
                    RSP_RDATA <= RF_DATA_OUT;
                    RSP_VALID <= NREQ'(1) << req_id;
                    state     <= RESP;
                end
                RESP: begin
                    RF_CE <= '0;
                    if (RSP_READY[req_id]) begin
                        RSP_VALID <= '0;
                        BUSY      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    RF_CE     <= '0;
                    RSP_VALID <= '0;
                    BUSY      <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/reg_file_ctrl.md
Name: reg_file_ctrl

Overview:
- Access controller that shares the 4 x 8-bit register file between NREQ requesters (core datapath, debug port).
- Accepts read/write requests over valid/ready and arbitrates round-robin.
- Sequences the file's ADDR/CE/DATA_IN lines, respecting its one-cycle registered read latency.
- Returns a response (read data or write acknowledge) to the granted requester.

Parameters:
- NREQ, 2, number of requesters; requester 0 wins the first arbitration after reset.
- ADDR_W, 2, register address width; the file holds 2**ADDR_W registers.
- DATA_W, 8, register data width.

Ports:
- CLK  input  1  clock, rising edge.
- RSTN  input  1  asynchronous, active-low reset.
- REQ_VALID  input  NREQ  request valid, one bit per requester.
- REQ_READY  output  NREQ  request accepted, one-hot or zero.
- REQ_WE  input  NREQ  1 = write, 0 = read, per requester.
- REQ_ADDR  input  NREQ*ADDR_W  flattened; requester i at bits [i*ADDR_W +: ADDR_W].
- REQ_WDATA  input  NREQ*DATA_W  flattened write data, same packing.
- RSP_VALID  output  NREQ  response valid to the original requester, one-hot or zero.
- RSP_READY  input  NREQ  response consumed.
- RSP_RDATA  output  DATA_W  read data; holds the last write data for write responses.
- RF_ADDR  output  ADDR_W  to register file ADDR.
- RF_CE  output  2**ADDR_W  to register file CE, one-hot during a write.
- RF_DATA_IN  output  DATA_W  to register file DATA_IN.
- RF_DATA_OUT  input  DATA_W  from register file DATA_OUT.
- BUSY  output  1  high in any state other than IDLE.

Behaviour:
- Reset (RSTN low, asynchronous): state IDLE, REQ_READY=0, RSP_VALID=0, RSP_RDATA=0, RF_ADDR=0, RF_CE=0, RF_DATA_IN=0, BUSY=0, round-robin pointer last_grant=NREQ-1.
- An in-flight transaction is aborted with no response. A write already committed by the file stays committed.
- FSM states: IDLE -> ACCESS -> (CAPTURE if read) -> RESP -> IDLE.
- IDLE:
  - If any REQ_VALID is high, grant the first requester at or after (last_grant+1) mod NREQ.
  - REQ_READY[g]=1 combinationally in this cycle only.
  - On the edge: latch id, we, addr and wdata; update last_grant=g; go to ACCESS.
  - With no request, stay in IDLE with all RF_CE=0.
- ACCESS, 1 cycle:
  - RF_ADDR=addr and RF_DATA_IN=wdata, both registered outputs.
  - RF_CE=onehot(addr) if we, else 0.
  - Write: the file commits on the edge ending ACCESS; next state RESP.
  - Read: the file registers DATA_r[addr] on that edge; next state CAPTURE.
- CAPTURE, 1 cycle:
  - RF_ADDR stays held, so the file's output stays stable; RF_CE=0.
  - RSP_RDATA<=RF_DATA_OUT on the edge; go to RESP.
- RESP:
  - RSP_VALID[id]=1, RSP_RDATA stable, RF_CE=0.
  - Stay until RSP_READY[id]=1, then go to IDLE. RSP_READY of other requesters is ignored.
- Latency:
  - Request accept to RSP_VALID is 2 cycles for a write and 3 cycles for a read.
  - Minimum throughput is one transaction per 3 cycles for a write and per 4 cycles for a read, with RSP_READY tied high.
- Only one transaction is outstanding at a time. REQ_READY=0 in every state except IDLE, so requests arriving meanwhile wait.
- Read-after-write to the same address returns the new value, because the write completes before the next ACCESS.
- Simultaneous requests in IDLE: the round-robin pointer decides. No requester waits more than NREQ-1 grants.
- A requester may drop REQ_VALID before it is granted; no state is held for it.
- An out-of-range requester index cannot occur; the grant is always one-hot.
- The register file resets its contents to unknown, so reading a register before it has been written returns X. This is not an error inside this block.
- RF_CE is never multi-hot. RF_CE is never nonzero outside ACCESS.

Decomposition:
- Package reg_file_ctrl_pkg:
  - state enum (IDLE, ACCESS, CAPTURE, RESP).
  - localparams for default ADDR_W and DATA_W.
  - onehot_ce function: address in, CE vector out.
- Sub-module rr_arbiter:
  - Parameter NREQ.
  - Inputs req[NREQ], last_grant, en.
  - Outputs grant one-hot and grant_idx.
  - Combinational; the pointer register lives in reg_file_ctrl.

Test Plan:
- Single write then read: requester 0 writes addr 2 data 8'hA5, then reads addr 2. Required: RF_CE=4'b0100 for exactly 1 cycle; RSP_VALID[0] 2 cycles after write accept; read RSP_RDATA=8'hA5, 3 cycles after read accept.
- Fill and read back all four registers: write 8'h11, 8'h22, 8'h33, 8'h44 to addr 0-3, then read in order 3..0. Required: returned 8'h44, 8'h33, 8'h22, 8'h11.
- Contention: both requesters hold REQ_VALID continuously, req0 reading addr 1, req1 writing addr 1 with 8'h5C. Required: grants alternate 0,1,0,1; the second read by req0 returns 8'h5C.
- Response backpressure: RSP_READY[1]=0 for 5 cycles after RSP_VALID[1]. Required: RSP_VALID and RSP_RDATA held stable; BUSY=1; REQ_READY stays 0 for the pending req0; RF_CE=0.
- Reset mid-read: assert RSTN low during CAPTURE. Required: immediately RSP_VALID=0, RF_CE=0, BUSY=0. After release, req0 wins the first grant.
- Read-after-write back-to-back: req0 writes addr 3 8'hF0; on the cycle after the response handshake, req0 reads addr 3. Required: returns 8'hF0, with no stale data.
